// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment scan driver.
//   - SEG_0..SEG_F, SEG_BLANK : active-low segment patterns, bit order g..a
//   - SEG_ACTIVE, AN_ACTIVE   : asserted level of segment and anode pins
//   - hex_to_seg()            : nibble to active-low segment pattern
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic SEG_ACTIVE = 1'b0;
    localparam logic AN_ACTIVE  = 1'b0;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to active-low segment decoder.
//   nib_i [3:0] : hex value
//   seg_o [6:0] : segments g..a, active low
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(nib_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for NUM_DIGITS common-anode
// seven-segment digits with tear-free (frame boundary) data update,
// leading-zero suppression and a global enable.
//   CLK, RST_N : clock, synchronous active-low reset
//   LOAD       : strobe capturing DATA_IN / DP_IN
//   DATA_IN    : packed nibbles, nibble k drives digit k (0 = rightmost)
//   DP_IN      : decimal point request per digit, 1 = lit
//   LZ_EN      : suppress leading zeros
//   ENABLE     : 0 blanks the display; scanning keeps running
//   SEG, DP    : segments g..a and decimal point, active low, registered
//   AN         : anode selects, active low one-hot, registered
//   LOAD_ACK   : one-cycle pulse when loaded data becomes visible
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      LOAD,
    input  logic [4*NUM_DIGITS-1:0]   DATA_IN,
    input  logic [NUM_DIGITS-1:0]     DP_IN,
    input  logic                      LZ_EN,
    input  logic                      ENABLE,
    output logic [6:0]                SEG,
    output logic                      DP,
    output logic [NUM_DIGITS-1:0]     AN,
    output logic                      LOAD_ACK
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW    = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DW-1:0]         active_q, active_d, shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, shd_dp_q, shd_dp_d;
    logic                  pending_q, pending_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  ack_q, ack_d;

    logic                  tick, last_idx, frame_end;
    logic [3:0]            cur_nib;
    logic                  cur_dp, cur_blank, hi_zero;
    logic [NUM_DIGITS-1:0] an_sel;
    logic [6:0]            dec_seg;

    // Prescaler and scan index
    always_comb begin
        tick      = (presc_q == CNT_W'(REFRESH_DIV - 1));
        last_idx  = (idx_q == IDX_W'(NUM_DIGITS - 1));
        frame_end = tick && last_idx;
        presc_d   = tick ? '0 : presc_q + CNT_W'(1);
        idx_d     = idx_q;
        if (tick) begin
            idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Load handshake. Shadow always follows LOAD; active only changes on a
    // frame boundary so a frame never mixes old and new digits. A LOAD on
    // the boundary itself bypasses shadow so it is not held for a full frame.
    always_comb begin
        shadow_d  = shadow_q;
        shd_dp_d  = shd_dp_q;
        active_d  = active_q;
        act_dp_d  = act_dp_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        if (LOAD) begin
            shadow_d  = DATA_IN;
            shd_dp_d  = DP_IN;
            pending_d = 1'b1;
        end
        if (frame_end) begin
            if (LOAD) begin
                active_d = DATA_IN;
                act_dp_d = DP_IN;
            end else if (pending_q) begin
                active_d = shadow_q;
                act_dp_d = shd_dp_q;
            end
            ack_d     = LOAD || pending_q;
            pending_d = 1'b0;
        end
    end

    // Digit mux plus leading-zero detection. Walking from the top digit
    // down, hi_zero stays set while every nibble from the top through k is 0.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        hi_zero   = 1'b1;
        an_sel    = {NUM_DIGITS{~AN_ACTIVE}};
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            hi_zero = hi_zero && (active_q[4*k +: 4] == 4'h0);
            if (idx_q == IDX_W'(k)) begin
                cur_nib   = active_q[4*k +: 4];
                cur_dp    = act_dp_q[k];
                cur_blank = LZ_EN && hi_zero && (k != 0);
                an_sel[k] = AN_ACTIVE;
            end
        end
    end

    seg7_hex_decode u_dec (
        .nib_i (cur_nib),
        .seg_o (dec_seg)
    );

    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = ~SEG_ACTIVE;
        an_d  = {NUM_DIGITS{~AN_ACTIVE}};
        if (ENABLE) begin
            seg_d = cur_blank ? SEG_BLANK : dec_seg;
            dp_d  = cur_dp ? SEG_ACTIVE : ~SEG_ACTIVE;
            an_d  = an_sel;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            presc_q   <= '0;
            idx_q     <= '0;
            active_q  <= '0;
            shadow_q  <= '0;
            act_dp_q  <= '0;
            shd_dp_q  <= '0;
            pending_q <= 1'b0;
            seg_q     <= SEG_BLANK;
            dp_q      <= ~SEG_ACTIVE;
            an_q      <= {NUM_DIGITS{~AN_ACTIVE}};
            ack_q     <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            act_dp_q  <= act_dp_d;
            shd_dp_q  <= shd_dp_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
            ack_q     <= ack_d;
        end
    end

    assign SEG      = seg_q;
    assign DP       = dp_q;
    assign AN       = an_q;
    assign LOAD_ACK = ack_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed test of seg7_scan_driver with
// NUM_DIGITS=4, REFRESH_DIV=4 (one frame = 16 cycles).
// Inputs are driven and outputs sampled on the falling edge.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          LOAD;
    logic [15:0]   DATA_IN;
    logic [3:0]    DP_IN;
    logic          LZ_EN;
    logic          ENABLE;
    logic [6:0]    SEG;
    logic          DP;
    logic [3:0]    AN;
    logic          LOAD_ACK;

    int nvec = 0;
    int nerr = 0;

    logic [3:0] cap_an  [16];
    logic [6:0] cap_seg [16];
    logic       cap_dp  [16];
    int         cap_acks;

    seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .LOAD     (LOAD),
        .DATA_IN  (DATA_IN),
        .DP_IN    (DP_IN),
        .LZ_EN    (LZ_EN),
        .ENABLE   (ENABLE),
        .SEG      (SEG),
        .DP       (DP),
        .AN       (AN),
        .LOAD_ACK (LOAD_ACK)
    );

    always #5 CLK = ~CLK;

    // Wait (bounded) for LOAD_ACK; returns at the falling edge of the ACK cycle.
    task automatic wait_ack(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge CLK);
            if (LOAD_ACK === 1'b1) found = 1'b1;
        end
    endtask

    // Record the next 16 cycles (one full frame) of outputs.
    task automatic capture_frame();
        cap_acks = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            cap_an[i]  = AN;
            cap_seg[i] = SEG;
            cap_dp[i]  = DP;
            if (LOAD_ACK === 1'b1) cap_acks++;
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        LOAD = 1'b1; DATA_IN = d; DP_IN = p;
        @(negedge CLK);
        LOAD = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; LOAD = 1'b0; DATA_IN = '0; DP_IN = '0;
        LZ_EN = 1'b0; ENABLE = 1'b1;
        repeat (3) @(negedge CLK);
        nvec++;
        if (SEG !== 7'b1111111 || DP !== 1'b1 || AN !== 4'b1111 || LOAD_ACK !== 1'b0) begin
            nerr++;
            $display("FAIL reset: SEG=%b DP=%b AN=%b ACK=%b, want 1111111 1 1111 0", SEG, DP, AN, LOAD_ACK);
        end
        RST_N = 1'b1;
    endtask

    task automatic test_basic_frame();
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an  [4];
        logic       exp_dp  [4];
        bit found;
        exp_seg[0] = 7'b0001110; exp_seg[1] = 7'b0001000;
        exp_seg[2] = 7'b0100100; exp_seg[3] = 7'b1111001;
        exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
        exp_dp[0] = 1'b1; exp_dp[1] = 1'b1; exp_dp[2] = 1'b0; exp_dp[3] = 1'b1;
        do_load(16'h12AF, 4'b0100);
        wait_ack(40, found);
        nvec++;
        if (!found) begin
            nerr++;
            $display("FAIL basic_ack: no LOAD_ACK within 40 cycles, want one");
        end
        capture_frame();
        nvec++;
        if (cap_acks != 0) begin
            nerr++;
            $display("FAIL basic_ack_pulse: %0d extra ACK cycles, want 0", cap_acks);
        end
        for (int i = 0; i < 16; i++) begin
            nvec++;
            if (cap_an[i] !== exp_an[i/4] || cap_seg[i] !== exp_seg[i/4] || cap_dp[i] !== exp_dp[i/4]) begin
                nerr++;
                $display("FAIL basic_frame[%0d]: AN=%b SEG=%b DP=%b, want %b %b %b", i,
                         cap_an[i], cap_seg[i], cap_dp[i], exp_an[i/4], exp_seg[i/4], exp_dp[i/4]);
            end
        end
    endtask

    task automatic test_lz();
        logic [6:0] exp_a [4];
        logic [6:0] exp_b [4];
        logic [3:0] exp_an [4];
        bit found;
        exp_a[0] = 7'b1000000; exp_a[1] = 7'b1111000; exp_a[2] = 7'b1111111; exp_a[3] = 7'b1111111;
        exp_b[0] = 7'b1000000; exp_b[1] = 7'b1111111; exp_b[2] = 7'b1111111; exp_b[3] = 7'b1111111;
        exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
        LZ_EN = 1'b1;
        do_load(16'h0070, 4'b0000);
        wait_ack(40, found);
        nvec++;
        if (!found) begin
            nerr++;
            $display("FAIL lz_ack_0070: no LOAD_ACK within 40 cycles, want one");
        end
        capture_frame();
        for (int i = 0; i < 16; i++) begin
            nvec++;
            if (cap_seg[i] !== exp_a[i/4] || cap_an[i] !== exp_an[i/4] || cap_dp[i] !== 1'b1) begin
                nerr++;
                $display("FAIL lz_0070[%0d]: AN=%b SEG=%b DP=%b, want %b %b 1", i,
                         cap_an[i], cap_seg[i], cap_dp[i], exp_an[i/4], exp_a[i/4]);
            end
        end
        do_load(16'h0000, 4'b0000);
        wait_ack(40, found);
        nvec++;
        if (!found) begin
            nerr++;
            $display("FAIL lz_ack_0000: no LOAD_ACK within 40 cycles, want one");
        end
        capture_frame();
        for (int i = 0; i < 16; i++) begin
            nvec++;
            if (cap_seg[i] !== exp_b[i/4] || cap_an[i] !== exp_an[i/4]) begin
                nerr++;
                $display("FAIL lz_0000[%0d]: AN=%b SEG=%b, want %b %b", i,
                         cap_an[i], cap_seg[i], exp_an[i/4], exp_b[i/4]);
            end
        end
    endtask

    // Entered at the start of a frame (index 0, prescaler 0).
    task automatic test_back_to_back();
        int acks = 0;
        int ones = 0;
        bit found = 1'b0;
        do_load(16'h1111, 4'b0000);
        do_load(16'h2222, 4'b0000);
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge CLK);
            if (SEG === 7'b1111001) ones++;
            if (LOAD_ACK === 1'b1) begin
                acks++;
                found = 1'b1;
            end
        end
        nvec++;
        if (acks != 1) begin
            nerr++;
            $display("FAIL b2b_ack: %0d ACKs, want 1", acks);
        end
        capture_frame();
        nvec++;
        if (cap_acks != 0) begin
            nerr++;
            $display("FAIL b2b_extra_ack: %0d extra ACKs, want 0", cap_acks);
        end
        for (int i = 0; i < 16; i++) begin
            if (cap_seg[i] === 7'b1111001) ones++;
            nvec++;
            if (cap_seg[i] !== 7'b0100100) begin
                nerr++;
                $display("FAIL b2b_frame[%0d]: SEG=%b, want 0100100", i, cap_seg[i]);
            end
        end
        nvec++;
        if (ones != 0) begin
            nerr++;
            $display("FAIL b2b_no_1111: %0d cycles showed 1, want 0", ones);
        end
    endtask

    // Entered at the start of a frame; the boundary cycle is 15 cycles later.
    task automatic test_boundary_load();
        repeat (15) @(negedge CLK);
        LOAD = 1'b1; DATA_IN = 16'h5555; DP_IN = 4'b0000;
        @(negedge CLK);
        LOAD = 1'b0;
        nvec++;
        if (LOAD_ACK !== 1'b1) begin
            nerr++;
            $display("FAIL boundary_ack: ACK=%b, want 1", LOAD_ACK);
        end
        capture_frame();
        nvec++;
        if (cap_acks != 0) begin
            nerr++;
            $display("FAIL boundary_extra_ack: %0d extra ACKs, want 0", cap_acks);
        end
        for (int i = 0; i < 16; i++) begin
            nvec++;
            if (cap_seg[i] !== 7'b0010010) begin
                nerr++;
                $display("FAIL boundary_frame[%0d]: SEG=%b, want 0010010", i, cap_seg[i]);
            end
        end
    endtask

    // Entered at the start of a frame (n=0). Disabled outputs cover n=1..10;
    // re-enabled at n=10 (index 2), so index 2 shows at n=11,12, index 3 at n=13.
    task automatic test_enable();
        ENABLE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            nvec++;
            if (AN !== 4'b1111 || SEG !== 7'b1111111 || DP !== 1'b1) begin
                nerr++;
                $display("FAIL disable[%0d]: AN=%b SEG=%b DP=%b, want 1111 1111111 1", i, AN, SEG, DP);
            end
        end
        ENABLE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            nvec++;
            if (AN !== ((i < 2) ? 4'b1011 : 4'b0111) || SEG !== 7'b0010010) begin
                nerr++;
                $display("FAIL reenable[%0d]: AN=%b SEG=%b, want %b 0010010", i, AN, SEG,
                         (i < 2) ? 4'b1011 : 4'b0111);
            end
        end
    endtask

    task automatic test_reset_pending();
        int acks = 0;
        int bad  = 0;
        LZ_EN = 1'b0;
        do_load(16'h9999, 4'b1111);
        RST_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            nvec++;
            if (SEG !== 7'b1111111 || DP !== 1'b1 || AN !== 4'b1111 || LOAD_ACK !== 1'b0) begin
                nerr++;
                $display("FAIL reset_mid[%0d]: SEG=%b DP=%b AN=%b ACK=%b, want 1111111 1 1111 0",
                         i, SEG, DP, AN, LOAD_ACK);
            end
        end
        RST_N = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (LOAD_ACK === 1'b1) acks++;
            if (SEG !== 7'b1000000 || AN === 4'b1111 || DP !== 1'b1) bad++;
        end
        nvec++;
        if (acks != 0) begin
            nerr++;
            $display("FAIL reset_no_ack: %0d ACKs, want 0", acks);
        end
        nvec++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL reset_shows_zero: %0d cycles not showing 0, want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_lz();
        test_back_to_back();
        test_boundary_load();
        test_enable();
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for a bank of NUM_DIGITS common-anode seven-segment digits. It is the parametrised successor to the single-digit hex decoder. A host loads a packed hex word plus per-digit decimal points through a LOAD/LOAD_ACK handshake. The block scans digits at a programmable refresh rate, with tear-free frame-boundary update, leading-zero suppression and a global enable. It sits between the system register file and the board's segment/anode pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 50000, CLK cycles each digit stays lit (>=2)
CNT_W, $clog2(REFRESH_DIV), prescaler width (derived, not overridden)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  synchronous reset, active low
LOAD  in  1  single-cycle strobe: capture DATA_IN/DP_IN
DATA_IN  in  4*NUM_DIGITS  packed hex nibbles; nibble k [4k+3:4k] drives digit k (digit 0 = rightmost)
DP_IN  in  NUM_DIGITS  decimal point request per digit, 1 = lit
LZ_EN  in  1  1 = suppress leading zeros
ENABLE  in  1  0 = display dark, scanning continues
SEG  out  7  segments g..a (SEG[6]=g, SEG[0]=a), active low
DP  out  1  decimal point, active low
AN  out  NUM_DIGITS  digit anode selects, active low, one-hot-cold
LOAD_ACK  out  1  one-cycle pulse when loaded data becomes visible

Behaviour:
- Reset (RST_N=0 at a CLK edge): prescaler=0, scan index=0, active and shadow data=0, active and shadow DP=0, pending=0. Outputs: SEG=7'b1111111, DP=1, AN all 1, LOAD_ACK=0. Reset mid-frame or mid-load discards pending data and produces no ACK.
- Prescaler counts 0..REFRESH_DIV-1. At terminal count (tick) it wraps to 0 and the index advances by one, wrapping NUM_DIGITS-1 -> 0.
- Frame boundary is a tick while index = NUM_DIGITS-1.
- All outputs are registered. SEG/DP/AN reflect the index and active data one cycle after the index changes.
- Decode: 0-F to active-low patterns, in order 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Load handshake:
  - LOAD=1 copies DATA_IN/DP_IN into shadow and sets pending. A later LOAD before the boundary overwrites shadow; one ACK covers both.
  - At a frame boundary with pending=1: active <= shadow, pending <= 0, LOAD_ACK=1 for the following cycle.
  - LOAD coincident with a boundary: DATA_IN/DP_IN go directly to active, pending cleared, ACK next cycle.
  - LOAD is never stalled; there is no busy output.
- Leading-zero suppression (LZ_EN=1): digit k blanks (SEG=1111111) when active nibbles k..NUM_DIGITS-1 are all zero and k != 0. Digit 0 is never suppressed. DP is unaffected by suppression.
- ENABLE=0: AN all 1, SEG all 1, DP=1 from the next cycle. Prescaler, index and load logic keep running, and ACK still fires.
- NUM_DIGITS=1: every tick is a frame boundary and AN[0] stays 0 while enabled.

Decomposition:
- Package seg7_pkg:
  - 7-bit segment pattern constants SEG_0..SEG_F and SEG_BLANK.
  - Function hex_to_seg(nibble).
  - Constants SEG_ACTIVE = 1'b0 and AN_ACTIVE = 1'b0.
- Sub-module seg7_hex_decode: combinational 4-bit to 7-bit active-low decoder built on the package function. Instanced once after the digit mux.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4):
1. Reset, then LOAD DATA_IN=16'h12AF, DP_IN=4'b0100 -> LOAD_ACK at the first frame boundary. Next frame, each digit holds 4 cycles:
   - AN=1110, SEG=0001110 (F)
   - AN=1101, SEG=0001000 (A)
   - AN=1011, SEG=0100100 (2), DP=0
   - AN=0111, SEG=1111001 (1)
2. LZ_EN=1, load 16'h0070:
   - digit3 and digit2 SEG=1111111
   - digit1 SEG=1111000
   - digit0 SEG=1000000
   Load 16'h0000 -> only digit0 lit with SEG=1000000.
3. LOAD 16'h1111 then LOAD 16'h2222 within the same frame -> exactly one LOAD_ACK; display shows 2222 with no frame showing 1111.
4. LOAD 16'h5555 asserted exactly on the frame-boundary cycle -> ACK the next cycle; 5 (0010010) is visible from the next frame start.
5. ENABLE=0 for 10 cycles -> AN=1111, SEG=1111111, DP=1. On re-enable, scanning resumes at the index the free-running counter has reached.
6. Assert RST_N=0 mid-frame with pending=1 -> all outputs at reset values, no ACK, display shows 0 after release.
